// File: rtl/cond_seq_unit_pkg.sv
// Condition codes, flag bit positions, IT sequencer states and the shared condition evaluator.
// Pure declarations; no clocked logic.
package cond_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
        COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
        COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'ha, COND_LT = 4'hb,
        COND_GT = 4'hc, COND_LE = 4'hd, COND_AL = 4'he, COND_NV = 4'hf
    } cond_e;

    localparam int N_IDX = 3;
    localparam int Z_IDX = 2;
    localparam int C_IDX = 1;
    localparam int V_IDX = 0;

    typedef enum logic {IT_IDLE = 1'b0, IT_ACTIVE = 1'b1} it_state_e;

    // Returns {pass, undef}; the reserved code never passes.
    function automatic logic [1:0] cond_eval(input cond_e c, input logic [3:0] f);
        logic n, z, cf, v, p, u;
        n  = f[N_IDX];
        z  = f[Z_IDX];
        cf = f[C_IDX];
        v  = f[V_IDX];
        u  = 1'b0;
        case (c)
            COND_EQ: p = z;
            COND_NE: p = ~z;
            COND_CS: p = cf;
            COND_CC: p = ~cf;
            COND_MI: p = n;
            COND_PL: p = ~n;
            COND_VS: p = v;
            COND_VC: p = ~v;
            COND_HI: p = cf & ~z;
            COND_LS: p = ~cf | z;
            COND_GE: p = (n == v);
            COND_LT: p = (n != v);
            COND_GT: p = ~z & (n == v);
            COND_LE: p = z | (n != v);
            COND_AL: p = 1'b1;
            default: begin
                p = 1'b0;
                u = 1'b1;
            end
        endcase
        return {p, u};
    endfunction

endpackage

// File: rtl/cond_seq_unit_if.sv
// Decoder-to-datapath control bundle around the conditional-execution unit.
// master = decoder/pipeline side, slave = cond_seq_unit.
interface cond_seq_unit_if #(
    parameter int IT_MAX = 4
);
    localparam int CNT_W = $clog2(IT_MAX + 1);

    logic              valid_i;
    logic              stall;
    logic              flush;
    logic [3:0]        Cond;
    logic [3:0]        ALUFlags;
    logic [1:0]        FlagW;
    logic              PCS;
    logic              RegW;
    logic              MemW;
    logic              NoWrite;
    logic              ITStart;
    logic [3:0]        ITBase;
    logic [CNT_W-1:0]  ITLen;
    logic [IT_MAX-1:0] ITThen;
    logic              PCSrc;
    logic              RegWrite;
    logic              MemWrite;
    logic              CondEx;
    logic [3:0]        Flags;
    logic              ITActive;
    logic [CNT_W-1:0]  ITRemain;
    logic              Undef;

    modport master (
        output valid_i, stall, flush, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
               ITStart, ITBase, ITLen, ITThen,
        input  PCSrc, RegWrite, MemWrite, CondEx, Flags, ITActive, ITRemain, Undef
    );

    modport slave (
        input  valid_i, stall, flush, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
               ITStart, ITBase, ITLen, ITThen,
        output PCSrc, RegWrite, MemWrite, CondEx, Flags, ITActive, ITRemain, Undef
    );

endinterface

// File: rtl/cond_seq_unit_flag_reg.sv
// NZCV register split into independently enabled NZ and CV groups.
// One-cycle write latency; a group holds whenever its enable is low.
module flopenr #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk) begin
        if (!reset)
            q <= '0;
        else if (en)
            q <= d;
    end
endmodule

module cond_flag_reg (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] we,
    input  logic [3:0] d,
    output logic [3:0] q
);
    flopenr #(.WIDTH(2)) u_nz (
        .clk   (clk),
        .reset (reset),
        .en    (we[1]),
        .d     (d[3:2]),
        .q     (q[3:2])
    );

    flopenr #(.WIDTH(2)) u_cv (
        .clk   (clk),
        .reset (reset),
        .en    (we[0]),
        .d     (d[1:0]),
        .q     (q[1:0])
    );
endmodule

// File: rtl/cond_seq_unit.sv
// Condition evaluation, write gating and IT-block sequencing for the control path.
// Write controls are combinational; flags and sequencer state advance on accepted cycles only.
module cond_seq_unit #(
    parameter  int IT_MAX = 4,
    localparam int CNT_W  = $clog2(IT_MAX + 1)
) (
    input  logic           clk,
    input  logic           reset,
    cond_seq_unit_if.slave bus
);
    import cond_pkg::*;

    localparam int               SLOT_W    = (IT_MAX > 1) ? $clog2(IT_MAX) : 1;
    localparam logic [CNT_W-1:0] LEN_MAX   = CNT_W'(IT_MAX);
    localparam logic [0:0]       ST_IDLE   = 1'(IT_IDLE);
    localparam logic [0:0]       ST_ACTIVE = 1'(IT_ACTIVE);

    logic [0:0]        state_q;
    logic [SLOT_W-1:0] slot_q;
    logic [CNT_W-1:0]  remain_q;
    logic [3:0]        base_q;
    logic [IT_MAX-1:0] then_q;
    logic [3:0]        flags_q;

    logic       active, accept, it_open, len_ok;
    logic [3:0] eff_cond;
    logic [1:0] ev;
    logic       condex, undef, wr_ok;
    logic [1:0] flag_we;

    assign active = (state_q == ST_ACTIVE);
    assign accept = bus.valid_i & ~bus.stall & ~bus.flush;

    always_comb begin
        eff_cond = bus.Cond;
        if (active)
            eff_cond = {base_q[3:1], base_q[0] ^ ~then_q[slot_q]};
        ev      = cond_eval(cond_e'(eff_cond), flags_q);
        it_open = ~active & bus.ITStart;
        len_ok  = (bus.ITLen != '0) && (bus.ITLen <= LEN_MAX);
        // The IT instruction itself behaves as AL but never writes anything.
        condex  = it_open ? 1'b1 : ev[1];
        undef   = accept & (it_open ? ~len_ok : (ev[0] | (active & bus.ITStart)));
        wr_ok   = accept & condex & ~undef & ~it_open;
        flag_we = {2{wr_ok}} & bus.FlagW;
    end

    cond_flag_reg u_flags (
        .clk   (clk),
        .reset (reset),
        .we    (flag_we),
        .d     (bus.ALUFlags),
        .q     (flags_q)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            slot_q   <= '0;
            remain_q <= '0;
            base_q   <= '0;
            then_q   <= '0;
        end else if (bus.flush) begin
            state_q  <= ST_IDLE;
            slot_q   <= '0;
            remain_q <= '0;
        end else if (accept) begin
            if (!active) begin
                if (bus.ITStart && len_ok) begin
                    state_q  <= ST_ACTIVE;
                    slot_q   <= '0;
                    remain_q <= bus.ITLen;
                    base_q   <= bus.ITBase;
                    then_q   <= bus.ITThen;
                end
            end else begin
                // A misplaced ITStart inside the block still consumes its slot.
                slot_q   <= slot_q + SLOT_W'(1);
                remain_q <= remain_q - CNT_W'(1);
                if (remain_q == CNT_W'(1)) begin
                    state_q <= ST_IDLE;
                    slot_q  <= '0;
                end
            end
        end
    end

    assign bus.PCSrc    = reset & wr_ok & bus.PCS;
    assign bus.RegWrite = reset & wr_ok & bus.RegW & ~bus.NoWrite;
    assign bus.MemWrite = reset & wr_ok & bus.MemW;
    assign bus.CondEx   = reset & condex;
    assign bus.Undef    = reset & undef;
    assign bus.Flags    = reset ? flags_q : 4'b0000;
    assign bus.ITActive = reset & active;
    assign bus.ITRemain = reset ? remain_q : '0;

endmodule

// File: tb/tb_cond_seq_unit.sv
// Scoreboard bench: each driven cycle queues its expected outputs, popped and compared on the falling edge.
module tb_cond_seq_unit;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    cond_seq_unit_if #(.IT_MAX(4)) ifc ();

    cond_seq_unit #(.IT_MAX(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    typedef struct {
        string      nm;
        logic       p, r, m, ce, ud;
        logic [3:0] fl;
        logic       act;
        logic [2:0] rem;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic expect_o(input string nm, input logic p, input logic r, input logic m,
                            input logic ce, input logic ud, input logic [3:0] fl,
                            input logic act, input logic [2:0] rem);
        exp_t e;
        e.nm = nm; e.p = p; e.r = r; e.m = m; e.ce = ce; e.ud = ud;
        e.fl = fl; e.act = act; e.rem = rem;
        sb.push_back(e);
    endtask

    task automatic go();
        @(posedge clk);
        #1;
        reset        = 1'b1;
        ifc.valid_i  = 1'b1;
        ifc.stall    = 1'b0;
        ifc.flush    = 1'b0;
        ifc.Cond     = 4'he;
        ifc.ALUFlags = 4'h0;
        ifc.FlagW    = 2'b00;
        ifc.PCS      = 1'b0;
        ifc.RegW     = 1'b0;
        ifc.MemW     = 1'b0;
        ifc.NoWrite  = 1'b0;
        ifc.ITStart  = 1'b0;
        ifc.ITBase   = 4'h0;
        ifc.ITLen    = 3'd0;
        ifc.ITThen   = 4'b0000;
    endtask

    task automatic it_start(input logic [3:0] base, input logic [2:0] len, input logic [3:0] thn);
        ifc.ITStart = 1'b1;
        ifc.ITBase  = base;
        ifc.ITLen   = len;
        ifc.ITThen  = thn;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({e.nm, ".pcsrc"},  4'(ifc.PCSrc),    4'(e.p));
            chk({e.nm, ".regw"},   4'(ifc.RegWrite), 4'(e.r));
            chk({e.nm, ".memw"},   4'(ifc.MemWrite), 4'(e.m));
            chk({e.nm, ".condex"}, 4'(ifc.CondEx),   4'(e.ce));
            chk({e.nm, ".undef"},  4'(ifc.Undef),    4'(e.ud));
            chk({e.nm, ".flags"},  ifc.Flags,        e.fl);
            chk({e.nm, ".itact"},  4'(ifc.ITActive), 4'(e.act));
            chk({e.nm, ".itrem"},  4'(ifc.ITRemain), 4'(e.rem));
        end
    end

    initial begin
        // reset with raw controls high: everything forced low
        go(); reset = 1'b0; ifc.PCS = 1; ifc.RegW = 1; ifc.MemW = 1;
        expect_o("rst", 0, 0, 0, 0, 0, 4'h0, 0, 3'd0);
        go(); ifc.Cond = 4'h0; ifc.PCS = 1; ifc.RegW = 1; ifc.MemW = 1;
        expect_o("eq_z0", 0, 0, 0, 0, 0, 4'h0, 0, 3'd0);
        go(); ifc.FlagW = 2'b01; ifc.ALUFlags = 4'hf;
        expect_o("wr_cv", 0, 0, 0, 1, 0, 4'h0, 0, 3'd0);
        go(); ifc.FlagW = 2'b10; ifc.ALUFlags = 4'h4;
        expect_o("wr_nz", 0, 0, 0, 1, 0, 4'h3, 0, 3'd0);
        go(); ifc.Cond = 4'h0; ifc.PCS = 1; ifc.RegW = 1; ifc.MemW = 1; ifc.NoWrite = 1;
        expect_o("eq_nowr", 1, 0, 1, 1, 0, 4'h7, 0, 3'd0);
        go(); ifc.Cond = 4'h0; ifc.RegW = 1;
        expect_o("eq_regw", 0, 1, 0, 1, 0, 4'h7, 0, 3'd0);
        go(); ifc.Cond = 4'hf; ifc.PCS = 1; ifc.RegW = 1; ifc.MemW = 1; ifc.FlagW = 2'b11;
        expect_o("nv", 0, 0, 0, 0, 1, 4'h7, 0, 3'd0);
        go(); ifc.valid_i = 0; ifc.FlagW = 2'b11; ifc.RegW = 1;
        expect_o("novld", 0, 0, 0, 1, 0, 4'h7, 0, 3'd0);
        go(); ifc.Cond = 4'h1; ifc.RegW = 1;
        expect_o("ne_z1", 0, 0, 0, 0, 0, 4'h7, 0, 3'd0);

        // IT NE, len 3, then=101, Z=1 -> slots fail/pass/fail
        go(); it_start(4'h1, 3'd3, 4'b0101); ifc.RegW = 1; ifc.PCS = 1;
        expect_o("it1_op", 0, 0, 0, 1, 0, 4'h7, 0, 3'd0);
        go(); ifc.RegW = 1;
        expect_o("it1_s0", 0, 0, 0, 0, 0, 4'h7, 1, 3'd3);
        go(); ifc.RegW = 1;
        expect_o("it1_s1", 0, 1, 0, 1, 0, 4'h7, 1, 3'd2);
        go(); ifc.RegW = 1;
        expect_o("it1_s2", 0, 0, 0, 0, 0, 4'h7, 1, 3'd1);
        go(); ifc.valid_i = 0;
        expect_o("it1_end", 0, 0, 0, 1, 0, 4'h7, 0, 3'd0);

        // stall two cycles, then flush mid-block
        go(); it_start(4'h0, 3'd4, 4'b0011);
        expect_o("it2_op", 0, 0, 0, 1, 0, 4'h7, 0, 3'd0);
        go(); ifc.stall = 1; ifc.RegW = 1;
        expect_o("stall_a", 0, 0, 0, 1, 0, 4'h7, 1, 3'd4);
        go(); ifc.stall = 1; ifc.RegW = 1;
        expect_o("stall_b", 0, 0, 0, 1, 0, 4'h7, 1, 3'd4);
        go(); ifc.RegW = 1;
        expect_o("it2_s0", 0, 1, 0, 1, 0, 4'h7, 1, 3'd4);
        go(); ifc.flush = 1; ifc.RegW = 1; ifc.FlagW = 2'b11;
        expect_o("flush", 0, 0, 0, 1, 0, 4'h7, 1, 3'd3);
        go(); ifc.valid_i = 0;
        expect_o("post_fl", 0, 0, 0, 1, 0, 4'h7, 0, 3'd0);

        // ITStart inside an active block
        go(); it_start(4'h0, 3'd2, 4'b0011);
        expect_o("it3_op", 0, 0, 0, 1, 0, 4'h7, 0, 3'd0);
        go(); it_start(4'h0, 3'd2, 4'b0011); ifc.RegW = 1;
        expect_o("nested", 0, 0, 0, 1, 1, 4'h7, 1, 3'd2);
        go(); ifc.RegW = 1;
        expect_o("it3_s1", 0, 1, 0, 1, 0, 4'h7, 1, 3'd1);
        go(); ifc.valid_i = 0;
        expect_o("it3_end", 0, 0, 0, 1, 0, 4'h7, 0, 3'd0);

        // illegal lengths
        go(); it_start(4'h0, 3'd0, 4'b0001); ifc.RegW = 1;
        expect_o("len0", 0, 0, 0, 1, 1, 4'h7, 0, 3'd0);
        go(); ifc.valid_i = 0;
        expect_o("len0_idle", 0, 0, 0, 1, 0, 4'h7, 0, 3'd0);
        go(); it_start(4'h0, 3'd5, 4'b0001);
        expect_o("len5", 0, 0, 0, 1, 1, 4'h7, 0, 3'd0);
        go(); ifc.valid_i = 0;
        expect_o("len5_idle", 0, 0, 0, 1, 0, 4'h7, 0, 3'd0);

        // AL base with an else slot -> reserved code on slot 1
        go(); it_start(4'he, 3'd2, 4'b0001);
        expect_o("it4_op", 0, 0, 0, 1, 0, 4'h7, 0, 3'd0);
        go(); ifc.RegW = 1;
        expect_o("al_then", 0, 1, 0, 1, 0, 4'h7, 1, 3'd2);
        go(); ifc.RegW = 1;
        expect_o("al_else", 0, 0, 0, 0, 1, 4'h7, 1, 3'd1);

        // reset in the middle of a block with Flags=1010
        go(); ifc.FlagW = 2'b11; ifc.ALUFlags = 4'ha;
        expect_o("wr_1010", 0, 0, 0, 1, 0, 4'h7, 0, 3'd0);
        go(); it_start(4'he, 3'd3, 4'b0111);
        expect_o("it5_op", 0, 0, 0, 1, 0, 4'ha, 0, 3'd0);
        go(); ifc.RegW = 1;
        expect_o("it5_s0", 0, 1, 0, 1, 0, 4'ha, 1, 3'd3);
        go(); reset = 1'b0; ifc.RegW = 1; ifc.PCS = 1; ifc.MemW = 1;
        expect_o("rst_mid", 0, 0, 0, 0, 0, 4'h0, 0, 3'd0);
        go(); ifc.valid_i = 0; ifc.Cond = 4'h0;
        expect_o("post_rst", 0, 0, 0, 0, 0, 4'h0, 0, 3'd0);

        @(negedge clk);
        #1;
        chk("sb_drain", 4'(sb.size()), 4'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
